// File: rtl/frame_buffer_arbiter.sv
// Frame buffer port arbiter.
// Shares one single-port 1-bit-wide frame buffer between three clients:
//   - display reads (highest priority, one-cycle request, fixed 2-cycle return),
//   - game-logic writes (held request/acknowledge handshake),
//   - a full-frame clear engine that sweeps the buffer writing zeros.
// Writes that have waited MAX_WAIT cycles or more get priority over the clear
// engine so game logic cannot be locked out for a whole frame sweep.
// At most one buffer operation is issued per cycle. Every buffer-facing signal
// and every handshake output comes straight from a flop.

module frame_buffer_arbiter #(
    parameter int FRAME_PIXELS = 307200,
    parameter int MAX_WAIT     = 8
) (
    input  logic        Clk_100MHz,
    input  logic        Reset_n,
    input  logic        Rd_req,
    input  logic [18:0] Rd_addr,
    output logic        Rd_valid,
    output logic        Rd_data,
    input  logic        Wr_req,
    input  logic [18:0] Wr_addr,
    input  logic        Wr_data,
    output logic        Wr_ack,
    input  logic        Clear_start,
    output logic        Clear_busy,
    output logic [18:0] BRAM_addr,
    output logic        BRAM_en,
    output logic        BRAM_we,
    output logic        BRAM_din,
    input  logic        BRAM_Dout
);

    // Address bounds; the 20-bit limit lets a 19-bit address be compared
    // against a frame of exactly 2^19 pixels without overflow.
    localparam logic [19:0] PIXEL_LIMIT = 20'(FRAME_PIXELS);
    localparam logic [18:0] LAST_ADDR   = 19'(FRAME_PIXELS - 1);
    localparam logic [3:0]  WAIT_LIMIT  = 4'(MAX_WAIT);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [18:0] clr_cnt_reg;
    logic [18:0] clr_cnt_next;
    logic [3:0]  wait_cnt_reg;
    logic [3:0]  wait_cnt_next;

    // Arbitration decode
    logic rd_in_range;
    logic wr_in_range;
    logic wr_eligible;
    logic wr_starved;
    logic clear_hold;
    logic grant_rd;
    logic grant_wr;
    logic clear_slot;

    // Registered buffer port and handshake outputs
    logic        bram_en_reg;
    logic        bram_en_next;
    logic        bram_we_reg;
    logic        bram_we_next;
    logic        bram_din_reg;
    logic        bram_din_next;
    logic [18:0] bram_addr_reg;
    logic [18:0] bram_addr_next;
    logic        wr_ack_reg;
    logic        wr_ack_next;

    // Read return pipeline: stage 1 is the cycle the buffer sees the
    // address, stage 2 is the cycle its output register holds the pixel.
    logic rd_issue_reg;
    logic rd_issue_next;
    logic rd_hit_reg;
    logic rd_hit_next;
    logic rd_valid_reg;
    logic rd_data_en_reg;

    assign rd_in_range = ({1'b0, Rd_addr} < PIXEL_LIMIT);
    assign wr_in_range = ({1'b0, Wr_addr} < PIXEL_LIMIT);

    // A held write is not eligible in the cycle its ack is showing, so the
    // same request can never be written twice.
    assign wr_eligible = Wr_req && !wr_ack_reg;
    assign wr_starved  = (wait_cnt_reg >= WAIT_LIMIT);

    // The clear engine owns non-read slots while sweeping, and also on the
    // edge that (re)starts it, so normal writes wait behind it.
    assign clear_hold = (state_reg == CLEAR) || Clear_start;

    assign grant_rd   = Rd_req;
    assign grant_wr   = !Rd_req && wr_eligible && (wr_starved || !clear_hold);
    assign clear_slot = !Rd_req && !grant_wr && (state_reg == CLEAR) && !Clear_start;

    // State register for the clear FSM, its sweep counter and the write wait counter
    always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            clr_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state logic: start/restart the sweep, advance it on each clear slot
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (Clear_start) begin
            state_next   = CLEAR;
            clr_cnt_next = '0;
        end else if (clear_slot) begin
            if (clr_cnt_reg == LAST_ADDR) begin
                state_next   = IDLE;
                clr_cnt_next = '0;
            end else begin
                clr_cnt_next = clr_cnt_reg + 19'd1;
            end
        end
    end

    // Starvation counter: counts ungranted request cycles, saturating at 15
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!Wr_req || grant_wr) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != 4'hF) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    // Output decode: build the buffer operation for the next cycle from the grant
    always_comb begin
        bram_en_next   = 1'b0;
        bram_we_next   = 1'b0;
        bram_din_next  = 1'b0;
        bram_addr_next = '0;
        wr_ack_next    = 1'b0;
        rd_issue_next  = 1'b0;
        rd_hit_next    = 1'b0;
        if (grant_rd) begin
            // Out-of-range reads still complete, but never touch the buffer.
            bram_en_next   = rd_in_range;
            bram_addr_next = rd_in_range ? Rd_addr : 19'd0;
            rd_issue_next  = 1'b1;
            rd_hit_next    = rd_in_range;
        end else if (grant_wr) begin
            // Out-of-range writes are acknowledged and silently dropped.
            bram_en_next   = wr_in_range;
            bram_we_next   = wr_in_range;
            bram_addr_next = wr_in_range ? Wr_addr : 19'd0;
            bram_din_next  = wr_in_range ? Wr_data : 1'b0;
            wr_ack_next    = 1'b1;
        end else if (clear_slot) begin
            bram_en_next   = 1'b1;
            bram_we_next   = 1'b1;
            bram_addr_next = clr_cnt_reg;
            bram_din_next  = 1'b0;
        end
    end

    // Output registers and read return pipeline; reset aborts anything in flight
    always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            bram_en_reg    <= 1'b0;
            bram_we_reg    <= 1'b0;
            bram_din_reg   <= 1'b0;
            bram_addr_reg  <= '0;
            wr_ack_reg     <= 1'b0;
            rd_issue_reg   <= 1'b0;
            rd_hit_reg     <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_data_en_reg <= 1'b0;
        end else begin
            bram_en_reg    <= bram_en_next;
            bram_we_reg    <= bram_we_next;
            bram_din_reg   <= bram_din_next;
            bram_addr_reg  <= bram_addr_next;
            wr_ack_reg     <= wr_ack_next;
            rd_issue_reg   <= rd_issue_next;
            rd_hit_reg     <= rd_hit_next;
            rd_valid_reg   <= rd_issue_reg;
            rd_data_en_reg <= rd_issue_reg && rd_hit_reg;
        end
    end

    assign BRAM_en    = bram_en_reg;
    assign BRAM_we    = bram_we_reg;
    assign BRAM_din   = bram_din_reg;
    assign BRAM_addr  = bram_addr_reg;
    assign Wr_ack     = wr_ack_reg;
    assign Rd_valid   = rd_valid_reg;
    assign Clear_busy = (state_reg == CLEAR);

    // The pixel itself is held by the buffer's own output register; it is
    // qualified by our registered enable so idle cycles, out-of-range reads
    // and reset all present 0.
    assign Rd_data = rd_data_en_reg & BRAM_Dout;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Testbench for frame_buffer_arbiter with a 16-pixel frame and MAX_WAIT=4.
// Directed table vectors, hand-written multi-cycle sequences, then random
// traffic checked cycle by cycle against a behavioural model of the arbiter
// rules and a model of the frame contents.

module tb_frame_buffer_arbiter;

    localparam int FP = 16;
    localparam int MW = 4;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        rd_valid;
    logic        rd_data;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic        wr_data;
    logic        wr_ack;
    logic        clear_start;
    logic        clear_busy;
    logic [18:0] bram_addr;
    logic        bram_en;
    logic        bram_we;
    logic        bram_din;
    logic        bram_dout;

    int errors = 0;
    int checks = 0;

    frame_buffer_arbiter #(
        .FRAME_PIXELS(FP),
        .MAX_WAIT    (MW)
    ) dut (
        .Clk_100MHz (clk),
        .Reset_n    (rst_n),
        .Rd_req     (rd_req),
        .Rd_addr    (rd_addr),
        .Rd_valid   (rd_valid),
        .Rd_data    (rd_data),
        .Wr_req     (wr_req),
        .Wr_addr    (wr_addr),
        .Wr_data    (wr_data),
        .Wr_ack     (wr_ack),
        .Clear_start(clear_start),
        .Clear_busy (clear_busy),
        .BRAM_addr  (bram_addr),
        .BRAM_en    (bram_en),
        .BRAM_we    (bram_we),
        .BRAM_din   (bram_din),
        .BRAM_Dout  (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame buffer: single port, read-first, one-cycle registered read.
    logic bram_mem [FP];
    logic bram_q;
    logic mem_load;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < FP; i++) bram_mem[i] <= (i % 3 != 0);
        end else if (bram_en) begin
            bram_q <= bram_mem[bram_addr[3:0]];
            if (bram_we) bram_mem[bram_addr[3:0]] <= bram_din;
        end
    end
    assign bram_dout = bram_q;

    function automatic logic pat(int i);
        return (i % 3 != 0);
    endfunction

    function automatic logic [31:0] pack(logic en, logic we, logic [18:0] a, logic d,
                                         logic ack, logic rv, logic rdv, logic busy);
        return {6'd0, en, we, (en ? a : 19'd0), (we ? d : 1'b0), ack, rv, (rv ? rdv : 1'b0), busy};
    endfunction

    function automatic logic [31:0] snap();
        return pack(bram_en, bram_we, bram_addr, bram_din, wr_ack, rd_valid, rd_data, clear_busy);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic idle_inputs();
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = 1'b0; clear_start = 1'b0;
    endtask

    // Directed vector table
    typedef struct {
        logic        rd;
        logic [18:0] raddr;
        logic        wr;
        logic [18:0] waddr;
        logic        wdata;
        logic        e_en;
        logic        e_we;
        logic [18:0] e_addr;
        logic        e_din;
        logic        e_ack;
        logic        e_rd;
    } vec_t;

    function automatic vec_t mk(int rd, int ra, int wr, int wa, int wd,
                                int en, int we, int ea, int ed, int ack, int erd);
        vec_t v;
        v.rd = 1'(rd); v.raddr = 19'(ra); v.wr = 1'(wr); v.waddr = 19'(wa); v.wdata = 1'(wd);
        v.e_en = 1'(en); v.e_we = 1'(we); v.e_addr = 19'(ea); v.e_din = 1'(ed);
        v.e_ack = 1'(ack); v.e_rd = 1'(erd);
        return v;
    endfunction

    // Behavioural model of the arbitration rules and frame contents
    logic m_mem [FP];
    bit   m_clear;
    int   m_idx;
    int   m_wait;
    bit   m_ack;
    bit   m_pv;
    bit   m_pd;

    task automatic model_reset();
        m_clear = 0; m_idx = 0; m_wait = 0; m_ack = 0; m_pv = 0; m_pd = 0;
        for (int i = 0; i < FP; i++) m_mem[i] = pat(i);
    endtask

    // One clock edge: pick the winner by priority, predict the next cycle.
    task automatic model_step(output logic [31:0] exp);
        int op;                 // 0 none, 1 read, 2 write, 3 clear
        bit wok;
        bit new_pv;
        bit new_pd;
        logic e_en, e_we, e_din, e_ack;
        logic [18:0] e_addr;
        wok = wr_req && !m_ack;
        if (rd_req) op = 1;
        else if (wok && m_wait >= MW) op = 2;
        else if (m_clear || clear_start) op = (m_clear && !clear_start) ? 3 : 0;
        else if (wok) op = 2;
        else op = 0;
        e_en = 0; e_we = 0; e_din = 0; e_ack = 0; e_addr = '0; new_pv = 0; new_pd = 0;
        if (op == 1) begin
            new_pv = 1;
            if (rd_addr < FP) begin
                e_en = 1; e_addr = rd_addr; new_pd = m_mem[rd_addr[3:0]];
            end
        end else if (op == 2) begin
            e_ack = 1;
            if (wr_addr < FP) begin
                e_en = 1; e_we = 1; e_addr = wr_addr; e_din = wr_data;
                m_mem[wr_addr[3:0]] = wr_data;
            end
        end else if (op == 3) begin
            e_en = 1; e_we = 1; e_addr = 19'(m_idx);
            m_mem[m_idx] = 1'b0;
        end
        if (wr_req && op != 2) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
        else m_wait = 0;
        if (clear_start) begin
            m_clear = 1; m_idx = 0;
        end else if (op == 3) begin
            if (m_idx == FP - 1) begin m_clear = 0; m_idx = 0; end
            else m_idx = m_idx + 1;
        end
        exp = pack(e_en, e_we, e_addr, e_din, e_ack, m_pv, m_pd, m_clear);
        m_pv = new_pv; m_pd = new_pd; m_ack = e_ack;
    endtask

    initial begin
        vec_t tbl [11];
        logic [31:0] exp;
        int acks, writes, busy_cnt, wcnt, bad, nxt, n, miss, nz;
        bit found, wr_active;
        logic [31:0] acc;

        idle_inputs();
        mem_load = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("reset_state", snap(), 32'd0);
        mem_load = 1'b1;
        repeat (2) @(posedge clk);
        mem_load = 1'b0;
        release_reset();
        chk("after_reset_idle", snap(), 32'd0);

        // ---------------- table vectors ----------------
        tbl[0]  = mk(1, 10, 0, 0, 0,    1, 0, 10, 0, 0, 1);
        tbl[1]  = mk(0, 0, 1, 5, 0,     1, 1, 5, 0, 1, 0);
        tbl[2]  = mk(1, 5, 0, 0, 0,     1, 0, 5, 0, 0, 0);
        tbl[3]  = mk(1, 16, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 16, 1,    0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(1, 9, 1, 3, 1,     1, 0, 9, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 3, 1,     1, 1, 3, 1, 1, 0);
        tbl[7]  = mk(1, 3, 0, 0, 0,     1, 0, 3, 0, 0, 1);
        tbl[8]  = mk(0, 0, 1, 15, 1,    1, 1, 15, 1, 1, 0);
        tbl[9]  = mk(1, 15, 0, 0, 0,    1, 0, 15, 0, 0, 1);
        tbl[10] = mk(1, 2, 0, 0, 0,     1, 0, 2, 0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            rd_req = tbl[i].rd; rd_addr = tbl[i].raddr;
            wr_req = tbl[i].wr; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata;
            tick();
            chk($sformatf("vec%0d_issue", i), snap(),
                pack(tbl[i].e_en, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_din, tbl[i].e_ack, 1'b0, 1'b0, 1'b0));
            idle_inputs();
            tick();
            chk($sformatf("vec%0d_return", i), snap(),
                pack(1'b0, 1'b0, 19'd0, 1'b0, 1'b0, tbl[i].rd, tbl[i].e_rd, 1'b0));
            $display("vec %0d rd=%0b ra=%0d wr=%0b wa=%0d done", i, tbl[i].rd, tbl[i].raddr, tbl[i].wr, tbl[i].waddr);
        end

        // ---------------- held write: exactly one write and one ack ----------------
        acks = 0; writes = 0;
        wr_addr = 19'd5; wr_data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_req = (i < 2);
            tick();
            if (wr_ack) acks++;
            if (bram_en && bram_we && bram_addr == 19'd5 && bram_din) writes++;
        end
        idle_inputs();
        chk("held_write_acks", 32'(acks), 32'd1);
        chk("held_write_writes", 32'(writes), 32'd1);
        $display("held write: acks=%0d writes=%0d", acks, writes);

        // ---------------- full clear, no traffic ----------------
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        busy_cnt = 0; wcnt = 0; bad = 0; nxt = 0;
        for (int i = 0; i < 40; i++) begin
            if (clear_busy) busy_cnt++;
            if (bram_en && bram_we) begin
                if (bram_addr != 19'(nxt) || bram_din != 1'b0) bad++;
                nxt++; wcnt++;
            end
            tick();
        end
        nz = 0;
        for (int i = 0; i < FP; i++) if (bram_mem[i] !== 1'b0) nz++;
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("clear_write_count", 32'(wcnt), 32'd16);
        chk("clear_write_order", 32'(bad), 32'd0);
        chk("clear_mem_zero", 32'(nz), 32'd0);
        $display("clear: busy=%0d writes=%0d bad=%0d nonzero=%0d", busy_cnt, wcnt, bad, nz);

        // ---------------- starved write during clear ----------------
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        wr_req = 1'b1; wr_addr = 19'd7; wr_data = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            n++;
            if (bram_en && bram_we && bram_addr == 19'd7 && bram_din) found = 1;
        end
        wr_req = 1'b0;
        chk("starved_write_found", 32'(found), 32'd1);
        chk("starved_write_latency", 32'(n), 32'(MW + 1));
        $display("starved write: latency=%0d", n);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (!clear_busy) found = 1;
        end
        chk("clear_finishes_after_write", 32'(found), 32'd1);

        // ---------------- reads every cycle during clear ----------------
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        miss = 0;
        for (int i = 0; i < 20; i++) begin
            rd_req = 1'b1; rd_addr = 19'(i % FP);
            tick();
            if (!(bram_en && !bram_we && bram_addr == 19'(i % FP))) miss++;
        end
        chk("reads_during_clear_busy", 32'(clear_busy), 32'd1);
        chk("reads_during_clear_served", 32'(miss), 32'd0);
        idle_inputs();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (!clear_busy) found = 1;
        end
        chk("clear_finishes_after_reads", 32'(found), 32'd1);
        $display("reads during clear: missed=%0d", miss);

        // ---------------- reset mid-clear ----------------
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bram_en && bram_we && bram_addr == 19'd6) found = 1;
        end
        chk("reached_clear_addr6", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_clear_outputs", snap(), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        acc = snap();
        for (int i = 0; i < 5; i++) begin
            tick();
            acc = acc | snap();
        end
        chk("after_reset_quiet", acc, 32'd0);
        $display("reset mid-clear: post-release activity=%h", acc);

        // ---------------- reset with read in flight ----------------
        rd_req = 1'b1; rd_addr = 19'd2;
        tick();
        rd_req = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (rd_valid) n++;
            tick();
        end
        chk("reset_aborts_read", 32'(n), 32'd0);
        $display("reset mid-read: valids=%0d", n);

        // ---------------- random traffic against the model ----------------
        idle_inputs();
        rst_n = 1'b0;
        mem_load = 1'b1;
        repeat (2) @(posedge clk);
        mem_load = 1'b0;
        model_reset();
        release_reset();
        wr_active = 0;
        for (int c = 0; c < 3000; c++) begin
            rd_req  = ($urandom_range(0, 99) < 40);
            rd_addr = 19'($urandom_range(0, FP + 1));
            if (wr_active && m_ack) wr_active = 0;
            if (!wr_active && $urandom_range(0, 99) < 35) begin
                wr_active = 1;
                wr_addr = 19'($urandom_range(0, FP + 1));
                wr_data = 1'($urandom_range(0, 1));
            end
            wr_req = wr_active;
            clear_start = ($urandom_range(0, 149) == 0);
            model_step(exp);
            tick();
            chk($sformatf("random_c%0d", c), snap(), exp);
        end
        idle_inputs();
        for (int c = 0; c < 40; c++) begin
            model_step(exp);
            tick();
            chk($sformatf("drain_c%0d", c), snap(), exp);
        end
        for (int i = 0; i < FP; i++)
            chk($sformatf("final_mem_%0d", i), 32'(bram_mem[i]), 32'(m_mem[i]));
        $display("random phase complete: %0d checks so far", checks);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
